// File: rtl/decoder_stage.sv
// RV32I (+ optional M) decode stage: classifies each accepted instruction, extracts
// register fields and the immediate, and buffers results in a small FIFO toward issue.
module decoder_stage #(
   parameter bit          RV_M  = 1'b1,
   parameter int unsigned DEPTH = 2,
   parameter int unsigned PC_W  = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [PC_W-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [PC_W-1:0] out_pc,
   output logic [1:0]      out_unit,
   output logic [2:0]      out_sub_unit,
   output logic [2:0]      out_sel,
   output logic            out_imm_v,
   output logic [31:0]     out_imm,
   output logic [4:0]      out_rd,
   output logic [4:0]      out_rs1,
   output logic [4:0]      out_rs2,
   output logic            out_fence,
   output logic            out_ecall,
   output logic            out_ebreak,
   output logic            out_mret,
   output logic            out_illegal,
   output logic [15:0]     illegal_cnt
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = DEPTH[AW:0];

   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic [1:0]      unit;
      logic [2:0]      sub_unit;
      logic [2:0]      sel;
      logic            imm_v;
      logic [31:0]     imm;
      logic [4:0]      rd;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic            fence;
      logic            ecall;
      logic            ebreak;
      logic            mret;
      logic            illegal;
   } entry_t;

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_z;
   entry_t      dec;
   logic        legal;

   assign opcode = in_instr[6:0];
   assign funct3 = in_instr[14:12];
   assign funct7 = in_instr[31:25];
   assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
   assign imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
   assign imm_b  = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                    in_instr[11:8], 1'b0};
   assign imm_u  = {in_instr[31:12], 12'b0};
   assign imm_j  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                    in_instr[30:21], 1'b0};
   assign imm_z  = {27'b0, in_instr[19:15]};

   // Opcodes whose low bits are not 2'b11 never match a case item, so they fall to illegal.
   always_comb begin
      dec     = '0;
      legal   = 1'b1;
      dec.pc  = in_pc;
      dec.rd  = in_instr[11:7];
      dec.rs1 = in_instr[19:15];
      dec.rs2 = in_instr[24:20];
      case (opcode)
         7'b0110111: begin dec.sel = 3'd0; dec.imm_v = 1'b1; dec.imm = imm_u; end
         7'b0010111: begin dec.sel = 3'd1; dec.imm_v = 1'b1; dec.imm = imm_u; end
         7'b1101111: begin dec.sel = 3'd2; dec.imm_v = 1'b1; dec.imm = imm_j; end
         7'b1100111: begin
            dec.sel = 3'd3; dec.imm_v = 1'b1; dec.imm = imm_i;
            legal   = (funct3 == 3'b000);
         end
         7'b1100011: begin
            dec.sub_unit = 3'd1; dec.imm_v = 1'b1; dec.imm = imm_b;
            case (funct3)
               3'b000:  dec.sel = 3'd0;
               3'b001:  dec.sel = 3'd1;
               3'b100:  dec.sel = 3'd2;
               3'b101:  dec.sel = 3'd3;
               3'b110:  dec.sel = 3'd4;
               3'b111:  dec.sel = 3'd5;
               default: legal = 1'b0;
            endcase
         end
         7'b0000011: begin
            dec.unit = 2'd1; dec.imm_v = 1'b1; dec.imm = imm_i;
            case (funct3)
               3'b000:  dec.sel = 3'd0;
               3'b001:  dec.sel = 3'd1;
               3'b010:  dec.sel = 3'd2;
               3'b100:  dec.sel = 3'd3;
               3'b101:  dec.sel = 3'd4;
               default: legal = 1'b0;
            endcase
         end
         7'b0100011: begin
            dec.unit = 2'd1; dec.sub_unit = 3'd1; dec.imm_v = 1'b1; dec.imm = imm_s;
            case (funct3)
               3'b000:  dec.sel = 3'd0;
               3'b001:  dec.sel = 3'd1;
               3'b010:  dec.sel = 3'd2;
               default: legal = 1'b0;
            endcase
         end
         7'b0010011: begin
            dec.imm_v = 1'b1; dec.imm = imm_i;
            case (funct3)
               3'b000: dec.sub_unit = 3'd2;
               3'b010: begin dec.sub_unit = 3'd3; dec.sel = 3'd0; end
               3'b011: begin dec.sub_unit = 3'd3; dec.sel = 3'd1; end
               3'b100: begin dec.sub_unit = 3'd3; dec.sel = 3'd2; end
               3'b110: begin dec.sub_unit = 3'd3; dec.sel = 3'd3; end
               3'b111: begin dec.sub_unit = 3'd3; dec.sel = 3'd4; end
               3'b001: begin dec.sub_unit = 3'd4; legal = (funct7 == 7'b0000000); end
               default: begin
                  dec.sub_unit = 3'd4;
                  if (funct7 == 7'b0000000)      dec.sel = 3'd1;
                  else if (funct7 == 7'b0100000) dec.sel = 3'd2;
                  else                           legal = 1'b0;
               end
            endcase
         end
         7'b0110011: begin
            if (funct7 == 7'b0000001) begin
               dec.unit = 2'd3; dec.sel = funct3;
               legal    = RV_M;
            end else if (funct7 == 7'b0000000) begin
               case (funct3)
                  3'b000:  dec.sub_unit = 3'd2;
                  3'b001:  dec.sub_unit = 3'd4;
                  3'b010:  begin dec.sub_unit = 3'd3; dec.sel = 3'd0; end
                  3'b011:  begin dec.sub_unit = 3'd3; dec.sel = 3'd1; end
                  3'b100:  begin dec.sub_unit = 3'd3; dec.sel = 3'd2; end
                  3'b101:  begin dec.sub_unit = 3'd4; dec.sel = 3'd1; end
                  3'b110:  begin dec.sub_unit = 3'd3; dec.sel = 3'd3; end
                  default: begin dec.sub_unit = 3'd3; dec.sel = 3'd4; end
               endcase
            end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
               dec.sub_unit = 3'd2; dec.sel = 3'd1;
            end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
               dec.sub_unit = 3'd4; dec.sel = 3'd2;
            end else begin
               legal = 1'b0;
            end
         end
         7'b0001111: begin
            dec.fence = 1'b1;
            legal     = (funct3 == 3'b000) || (funct3 == 3'b001);
         end
         7'b1110011: begin
            case (funct3)
               3'b000: begin
                  if (in_instr == 32'h0000_0073)      dec.ecall  = 1'b1;
                  else if (in_instr == 32'h0010_0073) dec.ebreak = 1'b1;
                  else if (in_instr == 32'h3020_0073) dec.mret   = 1'b1;
                  else                                legal      = 1'b0;
               end
               3'b001: begin dec.unit = 2'd2; dec.sel = 3'd0; end
               3'b010: begin dec.unit = 2'd2; dec.sel = 3'd1; end
               3'b011: begin dec.unit = 2'd2; dec.sel = 3'd2; end
               3'b101: begin dec.unit = 2'd2; dec.sel = 3'd0; dec.imm_v = 1'b1; dec.imm = imm_z; end
               3'b110: begin dec.unit = 2'd2; dec.sel = 3'd1; dec.imm_v = 1'b1; dec.imm = imm_z; end
               3'b111: begin dec.unit = 2'd2; dec.sel = 3'd2; dec.imm_v = 1'b1; dec.imm = imm_z; end
               default: legal = 1'b0;
            endcase
         end
         default: legal = 1'b0;
      endcase
      if (!legal) begin
         dec         = '0;
         dec.pc      = in_pc;
         dec.illegal = 1'b1;
      end
   end

   entry_t        mem [DEPTH];
   entry_t        head;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          push, pop;

   assign out_valid = (count != '0);
   assign pop       = out_valid & out_ready;
   assign in_ready  = (count < FULL) | pop;
   assign push      = in_valid & in_ready;

   // flush wins over push and pop; illegal_cnt survives it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count       <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         illegal_cnt <= '0;
         for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      end else if (flush) begin
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= dec;
            wr_ptr      <= wr_ptr + 1'b1;
            if (dec.illegal && illegal_cnt != 16'hFFFF) illegal_cnt <= illegal_cnt + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (!push && pop) count <= count - 1'b1;
      end
   end

   assign head         = mem[rd_ptr];
   assign out_pc       = head.pc;
   assign out_unit     = head.unit;
   assign out_sub_unit = head.sub_unit;
   assign out_sel      = head.sel;
   assign out_imm_v    = head.imm_v;
   assign out_imm      = head.imm;
   assign out_rd       = head.rd;
   assign out_rs1      = head.rs1;
   assign out_rs2      = head.rs2;
   assign out_fence    = head.fence;
   assign out_ecall    = head.ecall;
   assign out_ebreak   = head.ebreak;
   assign out_mret     = head.mret;
   assign out_illegal  = head.illegal;

endmodule

// File: tb/tb_decoder_stage.sv
// Scoreboard bench for decoder_stage: one instance with the M extension, one without.
module tb_decoder_stage;

   typedef struct packed {
      logic [31:0] pc;
      logic [1:0]  unit;
      logic [2:0]  sub_unit;
      logic [2:0]  sel;
      logic        imm_v;
      logic [31:0] imm;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic        fence;
      logic        ecall;
      logic        ebreak;
      logic        mret;
      logic        illegal;
   } ent_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic flush_m = 1'b0;

   logic        in_valid_m = 1'b0, in_ready_m, out_valid_m, out_ready_m = 1'b0;
   logic [31:0] in_instr_m = '0, in_pc_m = '0, out_pc_m, out_imm_m;
   logic [1:0]  out_unit_m;
   logic [2:0]  out_sub_unit_m, out_sel_m;
   logic        out_imm_v_m, out_fence_m, out_ecall_m, out_ebreak_m, out_mret_m, out_illegal_m;
   logic [4:0]  out_rd_m, out_rs1_m, out_rs2_m;
   logic [15:0] illegal_cnt_m;

   logic        in_valid_n = 1'b0, in_ready_n, out_valid_n, out_ready_n = 1'b0;
   logic [31:0] in_instr_n = '0, in_pc_n = '0, out_pc_n, out_imm_n;
   logic [1:0]  out_unit_n;
   logic [2:0]  out_sub_unit_n, out_sel_n;
   logic        out_imm_v_n, out_fence_n, out_ecall_n, out_ebreak_n, out_mret_n, out_illegal_n;
   logic [4:0]  out_rd_n, out_rs1_n, out_rs2_n;
   logic [15:0] illegal_cnt_n;

   ent_t head_m, head_n, got_m, got_n, exp_m, exp_n, nxt_m, nxt_n;
   ent_t sb_m [$];
   ent_t sb_n [$];
   logic pop_m, pop_n;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   decoder_stage #(.RV_M(1'b1), .DEPTH(2), .PC_W(32)) dut_m (
      .clk(clk), .rst(rst), .flush(flush_m),
      .in_valid(in_valid_m), .in_ready(in_ready_m), .in_instr(in_instr_m), .in_pc(in_pc_m),
      .out_valid(out_valid_m), .out_ready(out_ready_m), .out_pc(out_pc_m),
      .out_unit(out_unit_m), .out_sub_unit(out_sub_unit_m), .out_sel(out_sel_m),
      .out_imm_v(out_imm_v_m), .out_imm(out_imm_m),
      .out_rd(out_rd_m), .out_rs1(out_rs1_m), .out_rs2(out_rs2_m),
      .out_fence(out_fence_m), .out_ecall(out_ecall_m), .out_ebreak(out_ebreak_m),
      .out_mret(out_mret_m), .out_illegal(out_illegal_m), .illegal_cnt(illegal_cnt_m)
   );

   decoder_stage #(.RV_M(1'b0), .DEPTH(2), .PC_W(32)) dut_n (
      .clk(clk), .rst(rst), .flush(1'b0),
      .in_valid(in_valid_n), .in_ready(in_ready_n), .in_instr(in_instr_n), .in_pc(in_pc_n),
      .out_valid(out_valid_n), .out_ready(out_ready_n), .out_pc(out_pc_n),
      .out_unit(out_unit_n), .out_sub_unit(out_sub_unit_n), .out_sel(out_sel_n),
      .out_imm_v(out_imm_v_n), .out_imm(out_imm_n),
      .out_rd(out_rd_n), .out_rs1(out_rs1_n), .out_rs2(out_rs2_n),
      .out_fence(out_fence_n), .out_ecall(out_ecall_n), .out_ebreak(out_ebreak_n),
      .out_mret(out_mret_n), .out_illegal(out_illegal_n), .illegal_cnt(illegal_cnt_n)
   );

   assign head_m = {out_pc_m, out_unit_m, out_sub_unit_m, out_sel_m, out_imm_v_m, out_imm_m,
                    out_rd_m, out_rs1_m, out_rs2_m, out_fence_m, out_ecall_m, out_ebreak_m,
                    out_mret_m, out_illegal_m};
   assign head_n = {out_pc_n, out_unit_n, out_sub_unit_n, out_sel_n, out_imm_v_n, out_imm_n,
                    out_rd_n, out_rs1_n, out_rs2_n, out_fence_n, out_ecall_n, out_ebreak_n,
                    out_mret_n, out_illegal_n};

   function automatic ent_t mk(input logic [31:0] pc, input logic [1:0] u, input logic [2:0] s,
                               input logic [2:0] sel, input logic iv, input logic [31:0] imm,
                               input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
      ent_t e;
      e = '0;
      e.pc = pc; e.unit = u; e.sub_unit = s; e.sel = sel; e.imm_v = iv; e.imm = imm;
      e.rd = rd; e.rs1 = rs1; e.rs2 = rs2;
      return e;
   endfunction

   function automatic ent_t mk_ill(input logic [31:0] pc);
      ent_t e;
      e = '0;
      e.pc = pc;
      e.illegal = 1'b1;
      return e;
   endfunction

   // One clock: note handshakes just before the edge, update scoreboards just after it.
   task automatic cycle();
      logic am, an, fl;
      am    = in_valid_m && in_ready_m;
      an    = in_valid_n && in_ready_n;
      fl    = flush_m;
      pop_m = out_valid_m && out_ready_m;
      pop_n = out_valid_n && out_ready_n;
      got_m = head_m;
      got_n = head_n;
      @(posedge clk);
      #1;
      if (fl) begin
         sb_m.delete();
         pop_m = 1'b0;
      end else begin
         if (pop_m) begin
            if (sb_m.size() > 0) exp_m = sb_m.pop_front();
            else                 exp_m = 'x;
         end
         if (am) sb_m.push_back(nxt_m);
      end
      if (pop_n) begin
         if (sb_n.size() > 0) exp_n = sb_n.pop_front();
         else                 exp_n = 'x;
      end
      if (an) sb_n.push_back(nxt_n);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (out_valid_m !== 1'b0) begin
         n_errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid_m);
      end
      n_checks++;
      if (illegal_cnt_m !== 16'd0) begin
         n_errors++; $display("FAIL reset_illegal_cnt: got %0d want 0", illegal_cnt_m);
      end
      n_checks++;
      if (head_m !== '0) begin
         n_errors++; $display("FAIL reset_fields: got %h want 0", head_m);
      end
      rst = 1'b0;
      #1;
      n_checks++;
      if (in_ready_m !== 1'b1) begin
         n_errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready_m);
      end
      sb_m.delete();
      sb_n.delete();
   endtask

   task automatic test_decode_stream();
      logic [31:0] ins [4];
      ent_t        e   [4];
      int          pops;
      ins[0] = 32'hFFF10093; e[0] = mk(32'h100, 2'd0, 3'd2, 3'd0, 1'b1, 32'hFFFFFFFF, 5'd1, 5'd2, 5'd31);
      ins[1] = 32'hFE000EE3; e[1] = mk(32'h104, 2'd0, 3'd1, 3'd0, 1'b1, 32'hFFFFFFFC, 5'd29, 5'd0, 5'd0);
      ins[2] = 32'h00112623; e[2] = mk(32'h108, 2'd1, 3'd1, 3'd2, 1'b1, 32'd12, 5'd12, 5'd2, 5'd1);
      ins[3] = 32'h008000EF; e[3] = mk(32'h10C, 2'd0, 3'd0, 3'd2, 1'b1, 32'd8, 5'd1, 5'd0, 5'd8);
      pops = 0;
      out_ready_m = 1'b1;
      for (int i = 0; i < 7; i++) begin
         in_valid_m = (i < 4);
         if (i < 4) begin
            in_instr_m = ins[i];
            in_pc_m    = 32'h100 + 32'(4 * i);
            nxt_m      = e[i];
         end
         cycle();
         if (i == 0) begin
            n_checks++;
            if (out_valid_m !== 1'b1) begin
               n_errors++; $display("FAIL latency_out_valid: got %b want 1", out_valid_m);
            end
         end
         if (pop_m) begin
            pops++;
            n_checks++;
            if (got_m !== exp_m) begin
               n_errors++; $display("FAIL decode_stream[%0d]: got %h want %h", i, got_m, exp_m);
            end
         end
      end
      n_checks++;
      if (pops != 4) begin
         n_errors++; $display("FAIL decode_stream_pops: got %0d want 4", pops);
      end
   endtask

   task automatic test_back_to_back();
      localparam logic [8:0] V    = 9'b000011111;
      localparam logic [8:0] ORDY = 9'b111011000;
      localparam logic [8:0] RDY  = 9'b111011011;
      logic [31:0] ins [4];
      ent_t        e   [4];
      int          pops, k;
      ins[0] = 32'h002081B3; e[0] = mk(32'h200, 2'd0, 3'd2, 3'd0, 1'b0, 32'd0, 5'd3, 5'd1, 5'd2);
      ins[1] = 32'h402081B3; e[1] = mk(32'h204, 2'd0, 3'd2, 3'd1, 1'b0, 32'd0, 5'd3, 5'd1, 5'd2);
      ins[2] = 32'h0020F1B3; e[2] = mk(32'h208, 2'd0, 3'd3, 3'd4, 1'b0, 32'd0, 5'd3, 5'd1, 5'd2);
      ins[3] = 32'h4020D1B3; e[3] = mk(32'h20C, 2'd0, 3'd4, 3'd2, 1'b0, 32'd0, 5'd3, 5'd1, 5'd2);
      pops = 0;
      for (int s = 0; s < 9; s++) begin
         k = (s < 3) ? s : s - 1;
         in_valid_m  = V[s];
         out_ready_m = ORDY[s];
         if (V[s]) begin
            in_instr_m = ins[k];
            in_pc_m    = 32'h200 + 32'(4 * k);
            nxt_m      = e[k];
         end
         #1;
         n_checks++;
         if (in_ready_m !== RDY[s]) begin
            n_errors++; $display("FAIL b2b_in_ready[%0d]: got %b want %b", s, in_ready_m, RDY[s]);
         end
         cycle();
         if (pop_m) begin
            pops++;
            n_checks++;
            if (got_m !== exp_m) begin
               n_errors++; $display("FAIL b2b_order[%0d]: got %h want %h", s, got_m, exp_m);
            end
         end
      end
      in_valid_m = 1'b0;
      n_checks++;
      if (pops != 4 || out_valid_m !== 1'b0) begin
         n_errors++; $display("FAIL b2b_drain: got pops=%0d out_valid=%b want 4 0", pops, out_valid_m);
      end
   endtask

   task automatic test_flush();
      out_ready_m = 1'b0;
      in_valid_m  = 1'b1;
      in_instr_m  = 32'h002081B3; in_pc_m = 32'h300;
      nxt_m       = mk(32'h300, 2'd0, 3'd2, 3'd0, 1'b0, 32'd0, 5'd3, 5'd1, 5'd2);
      cycle();
      in_instr_m  = 32'h0020F1B3; in_pc_m = 32'h304;
      nxt_m       = mk(32'h304, 2'd0, 3'd3, 3'd4, 1'b0, 32'd0, 5'd3, 5'd1, 5'd2);
      cycle();
      in_instr_m  = 32'h402081B3; in_pc_m = 32'h308;
      nxt_m       = mk(32'h308, 2'd0, 3'd2, 3'd1, 1'b0, 32'd0, 5'd3, 5'd1, 5'd2);
      flush_m     = 1'b1;
      cycle();
      flush_m     = 1'b0;
      in_valid_m  = 1'b0;
      #1;
      n_checks++;
      if (out_valid_m !== 1'b0 || in_ready_m !== 1'b1) begin
         n_errors++;
         $display("FAIL flush_state: got out_valid=%b in_ready=%b want 0 1", out_valid_m, in_ready_m);
      end
      out_ready_m = 1'b1;
      in_valid_m  = 1'b1;
      in_instr_m  = 32'h123452B7; in_pc_m = 32'h30C;
      nxt_m       = mk(32'h30C, 2'd0, 3'd0, 3'd0, 1'b1, 32'h12345000, 5'd5, 5'd8, 5'd3);
      cycle();
      in_valid_m  = 1'b0;
      cycle();
      n_checks++;
      if (!pop_m || got_m !== exp_m) begin
         n_errors++; $display("FAIL flush_next_entry: got pop=%b %h want 1 %h", pop_m, got_m, exp_m);
      end
      n_checks++;
      if (out_valid_m !== 1'b0) begin
         n_errors++; $display("FAIL flush_dropped_input: got out_valid=%b want 0", out_valid_m);
      end
   endtask

   task automatic test_mext_illegal();
      logic [31:0] ins_m [4];
      ent_t        e_m   [4];
      ent_t        e_n   [2];
      int          pm, pn;
      ins_m[0] = 32'h02B535B3; e_m[0] = mk(32'h400, 2'd3, 3'd0, 3'd3, 1'b0, 32'd0, 5'd11, 5'd10, 5'd11);
      ins_m[1] = 32'h02009093; e_m[1] = mk_ill(32'h404);
      ins_m[2] = 32'h3002E273; e_m[2] = mk(32'h408, 2'd2, 3'd0, 3'd1, 1'b1, 32'd5, 5'd4, 5'd5, 5'd0);
      ins_m[3] = 32'h00000073; e_m[3] = mk(32'h40C, 2'd0, 3'd0, 3'd0, 1'b0, 32'd0, 5'd0, 5'd0, 5'd0);
      e_m[3].ecall = 1'b1;
      e_n[0] = mk_ill(32'h400);
      e_n[1] = mk_ill(32'h404);
      pm = 0;
      pn = 0;
      out_ready_m = 1'b1;
      out_ready_n = 1'b1;
      for (int s = 0; s < 5; s++) begin
         in_valid_m = (s < 4);
         in_valid_n = (s < 2);
         if (s < 4) begin
            in_instr_m = ins_m[s]; in_pc_m = 32'h400 + 32'(4 * s); nxt_m = e_m[s];
         end
         if (s < 2) begin
            in_instr_n = (s == 0) ? 32'h02B535B3 : 32'h00000000;
            in_pc_n    = 32'h400 + 32'(4 * s);
            nxt_n      = e_n[s];
         end
         cycle();
         if (s == 0) begin
            n_checks++;
            if (illegal_cnt_n !== 16'd1) begin
               n_errors++; $display("FAIL nom_illegal_cnt_1: got %0d want 1", illegal_cnt_n);
            end
         end
         if (s == 1) begin
            n_checks++;
            if (illegal_cnt_n !== 16'd2 || illegal_cnt_m !== 16'd1) begin
               n_errors++;
               $display("FAIL illegal_cnt_2: got n=%0d m=%0d want 2 1", illegal_cnt_n, illegal_cnt_m);
            end
         end
         if (pop_m) begin
            pm++;
            n_checks++;
            if (got_m !== exp_m) begin
               n_errors++; $display("FAIL mext_decode[%0d]: got %h want %h", s, got_m, exp_m);
            end
         end
         if (pop_n) begin
            pn++;
            n_checks++;
            if (got_n !== exp_n) begin
               n_errors++; $display("FAIL nom_decode[%0d]: got %h want %h", s, got_n, exp_n);
            end
         end
      end
      in_valid_m = 1'b0;
      in_valid_n = 1'b0;
      n_checks++;
      if (pm != 4 || pn != 2) begin
         n_errors++; $display("FAIL mext_pops: got %0d %0d want 4 2", pm, pn);
      end
   endtask

   task automatic test_async_reset();
      out_ready_m = 1'b0;
      in_valid_m  = 1'b1;
      in_instr_m  = 32'h002081B3; in_pc_m = 32'h500;
      nxt_m       = mk(32'h500, 2'd0, 3'd2, 3'd0, 1'b0, 32'd0, 5'd3, 5'd1, 5'd2);
      cycle();
      in_instr_m  = 32'hFFFFFFFF; in_pc_m = 32'h504;
      nxt_m       = mk_ill(32'h504);
      cycle();
      in_valid_m  = 1'b0;
      n_checks++;
      if (illegal_cnt_m !== 16'd2 || out_valid_m !== 1'b1) begin
         n_errors++;
         $display("FAIL pre_reset: got cnt=%0d out_valid=%b want 2 1", illegal_cnt_m, out_valid_m);
      end
      #2;
      rst = 1'b1;
      #1;
      n_checks++;
      if (out_valid_m !== 1'b0 || illegal_cnt_m !== 16'd0 || illegal_cnt_n !== 16'd0) begin
         n_errors++;
         $display("FAIL async_reset: got out_valid=%b cnt_m=%0d cnt_n=%0d want 0 0 0",
                  out_valid_m, illegal_cnt_m, illegal_cnt_n);
      end
      n_checks++;
      if (head_m !== '0) begin
         n_errors++; $display("FAIL async_reset_fields: got %h want 0", head_m);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      sb_m.delete();
      sb_n.delete();
   endtask

   initial begin
      test_reset();
      test_decode_stream();
      test_back_to_back();
      test_flush();
      test_mext_illegal();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete within 100000 time units");
      $fatal(1);
   end

endmodule
